prio_encoder83: RTL and testbench

Clocked 8-to-3 priority encoder with request latching and a valid/ready output handshake. It is the encode-side counterpart of the team's 3-to-8 decoder: code k on the output corresponds to one-hot bit k on the input, so a decoder driven by `code_o` regenerates the served request bit. Requests are collected into a pending register. Pending requests are then emitted one at a time, highest index first, to a downstream consumer that may apply backpressure.

---
 rtl/prio_encoder83_pkg.sv | 10 +
 rtl/prio_encoder83_msb_find8.sv | 14 +
 rtl/prio_encoder83.sv | 59 +++++
 tb/tb_prio_encoder83.sv | 126 ++++++++++++
 4 files changed

// File: rtl/prio_encoder83_pkg.sv
// prio_encoder83_pkg: shared request-width constants and the 3-to-8 one-hot helper
// used by both the encoder and its companion decoder.
package prio_encoder83_pkg;
    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx);
        return WIDTH'(1) << idx;
    endfunction
endpackage

// File: rtl/prio_encoder83_msb_find8.sv
// msb_find8: combinational MSB-first search returning the highest set index of an
// 8-bit vector plus an any-set flag.
module msb_find8 (
    input  logic [7:0] vec_i,
    output logic [2:0] idx_o,
    output logic       any_o
);
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < 8; i++)
            if (vec_i[i]) idx_o = 3'(i);
        any_o = |vec_i;
    end
endmodule

// File: rtl/prio_encoder83.sv
// prio_encoder83: latches requests into a pending set and issues them one code at a
// time, highest index first, over a valid/ready handshake.
module prio_encoder83
    import prio_encoder83_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int IDX_W_P = IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIDTH_P-1:0] req,
    output logic [IDX_W_P-1:0] code_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] pending_o,
    output logic               drop_o
);
    logic [WIDTH_P-1:0] pending_q, pending_d, req_m, clr;
    logic [IDX_W_P-1:0] code_q, code_d, top_idx;
    logic               valid_q, valid_d, drop_q, drop_d, any, load, serve;

    msb_find8 u_find (
        .vec_i(pending_q),
        .idx_o(top_idx),
        .any_o(any)
    );

    always_comb begin
        req_m     = en ? req : '0;
        load      = !valid_q || ready_i;
        serve     = load && any;
        clr       = serve ? onehot(top_idx) : '0;
        // set wins: a request on the bit being served re-pends it
        pending_d = (pending_q & ~clr) | req_m;
        code_d    = serve ? top_idx : code_q;
        valid_d   = load ? any : valid_q;
        drop_d    = |(req_m & pending_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
        end
    end

    assign pending_o = pending_q;
    assign code_o    = code_q;
    assign valid_o   = valid_q;
    assign drop_o    = drop_q;
endmodule

// File: tb/tb_prio_encoder83.sv
// tb_prio_encoder83: set-based reference model feeds an expected-code scoreboard;
// a negedge monitor pops on every handshake and checks all outputs.
module tb_prio_encoder83;
    logic       clk, rst_n, en, ready_i, valid_o, drop_o;
    logic [7:0] req, pending_o;
    logic [2:0] code_o;

    int checks = 0, errors = 0;

    logic [7:0] m_pend;
    logic [2:0] m_code;
    logic       m_valid, m_drop;
    logic [2:0] exp_q[$];

    prio_encoder83 dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .code_o(code_o), .valid_o(valid_o), .ready_i(ready_i),
        .pending_o(pending_o), .drop_o(drop_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int highest(input int x);
        return $clog2(x + 1) - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_code = 0; m_valid = 0; m_drop = 0;
            exp_q.delete();
        end else begin
            logic [7:0] rm, clr;
            rm  = en ? req : 8'h00;
            clr = 0;
            if (!m_valid || ready_i) begin
                if (m_pend != 0) begin
                    m_code  = 3'(highest(int'(m_pend)));
                    clr     = 8'(1 << m_code);
                    m_valid = 1;
                    exp_q.push_back(m_code);
                end else m_valid = 0;
            end
            m_drop = |(rm & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | rm;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pending", int'(pending_o), int'(m_pend));
            chk("valid", int'(valid_o), int'(m_valid));
            chk("drop", int'(drop_o), int'(m_drop));
            if (valid_o) chk("code", int'(code_o), int'(m_code));
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
                else chk("transfer_code", int'(code_o), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic e, input logic [7:0] r, input logic rd);
        en = e; req = r; ready_i = rd;
        @(posedge clk); #2;
    endtask

    initial begin
        rst_n = 0; en = 0; req = 0; ready_i = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        step(1, 8'h20, 1);
        repeat (4) step(1, 8'h00, 1);
        step(1, 8'h91, 1);
        repeat (5) step(1, 8'h00, 1);
        step(1, 8'h0C, 0);
        repeat (2) step(1, 8'h00, 0);
        step(1, 8'h80, 0);
        step(1, 8'h00, 0);
        repeat (5) step(1, 8'h00, 1);
        step(1, 8'h02, 0);
        step(1, 8'h00, 0);
        step(1, 8'h02, 0);
        step(1, 8'h00, 0);
        step(1, 8'h02, 0);
        repeat (3) step(1, 8'h00, 1);
        step(1, 8'h02, 1);
        step(1, 8'h02, 1);
        repeat (3) step(1, 8'h00, 1);
        repeat (3) step(0, 8'hFF, 1);
        step(1, 8'h06, 0);
        step(0, 8'h00, 0);
        repeat (4) step(0, 8'hFF, 1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom & $urandom), $urandom_range(0, 2) != 0);
        repeat (2) step(1, 8'hFF, 0);
        rst_n = 0;
        #1;
        chk("rst_pending", int'(pending_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_code", int'(code_o), 0);
        chk("rst_drop", int'(drop_o), 0);
        step(1, 8'h00, 1);
        rst_n = 1;
        repeat (3) step(1, 8'h00, 1);
        chk("post_rst_pending", int'(pending_o), 0);
        chk("post_rst_valid", int'(valid_o), 0);
        for (int i = 0; i < 100; i++)
            step(1, 8'($urandom & $urandom & $urandom), $urandom_range(0, 1) != 0);
        repeat (12) step(1, 8'h00, 1);
        chk("drain_pending", int'(pending_o), 0);
        chk("drain_valid", int'(valid_o), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
